// File: rtl/merlin_ibus_sram_rsp_pkg.sv
// Shared types and helpers for the instruction-bus SRAM responder.
package merlin_ibus_sram_rsp_pkg;

  localparam int unsigned XLEN = 32;

  // Hart privilege level encodings
  localparam logic [1:0] HPL_USER       = 2'b00;
  localparam logic [1:0] HPL_SUPERVISOR = 2'b01;
  localparam logic [1:0] HPL_MACHINE    = 2'b11;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } rsp_t;

  localparam int unsigned RSP_W = $bits(rsp_t);

  // Bit h set when privilege level h may fetch; turns the HPL check into a lookup.
  function automatic logic [3:0] hpl_allow_mask(input logic [1:0] min_hpl);
    logic [3:0] m;
    m = '0;
    for (int unsigned h = 0; h < 4; h++) begin
      m[h] = (2'(h) >= min_hpl);
    end
    return m;
  endfunction

endpackage

// File: rtl/merlin_ibus_sram_rsp_fifo.sv
// First-word fall-through FIFO; caller guarantees no write when full.
module merlin_fifo #(
  parameter int unsigned C_FIFO_WIDTH   = 33,
  parameter int unsigned C_FIFO_DEPTH_X = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clk_en_i,
  input  logic                    flush_i,
  input  logic                    wr_i,
  input  logic [C_FIFO_WIDTH-1:0] wdata_i,
  input  logic                    rd_i,
  output logic [C_FIFO_WIDTH-1:0] rdata_o,
  output logic                    empty_o
);

  localparam int unsigned DEPTH = 2 ** C_FIFO_DEPTH_X;
  localparam int unsigned PTR_W = C_FIFO_DEPTH_X + 1;

  logic [C_FIFO_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_rd   = rd_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[C_FIFO_DEPTH_X-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clk_en_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (clk_en_i & wr_i) begin
      mem_q[wr_ptr_q[C_FIFO_DEPTH_X-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/merlin_ibus_sram_rsp.sv
// Instruction-bus responder: decodes PFU fetches, reads a fixed-latency SRAM,
// and returns in-order responses through a credit-protected FIFO.
module merlin_ibus_sram_rsp
  import merlin_ibus_sram_rsp_pkg::*;
#(
  parameter int unsigned C_MEM_DEPTH_X      = 10,
  parameter logic [31:0] C_BASE_ADDR        = 32'h0,
  parameter int unsigned C_RD_LATENCY       = 1,
  parameter int unsigned C_RSP_FIFO_DEPTH_X = 2,
  parameter logic [1:0]  C_MIN_HPL          = HPL_USER
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clk_en_i,
  output logic                     ireqready_o,
  input  logic                     ireqvalid_i,
  input  logic [1:0]               ireqhpl_i,
  input  logic [31:0]              ireqaddr_i,
  input  logic                     irspready_i,
  output logic                     irspvalid_o,
  output logic                     irsprerr_o,
  output logic [31:0]              irspdata_o,
  output logic                     mem_en_o,
  output logic [C_MEM_DEPTH_X-1:0] mem_addr_o,
  input  logic [31:0]              mem_rdata_i
);

  localparam int unsigned    CNT_W   = C_RSP_FIFO_DEPTH_X + 1;
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(1) << C_RSP_FIFO_DEPTH_X;
  localparam logic [3:0]     HPL_OK  = hpl_allow_mask(C_MIN_HPL);

  if ((C_RD_LATENCY < 1) || (C_RD_LATENCY > 3) ||
      ((2 ** C_RSP_FIFO_DEPTH_X) < (C_RD_LATENCY + 1))) begin : g_param_err
    $error("merlin_ibus_sram_rsp: illegal C_RD_LATENCY or response FIFO too shallow");
  end

  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic [C_RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [C_RD_LATENCY-1:0] pipe_err_q, pipe_err_d;
  logic                    accept, pop, err, in_range, rsp_show, fifo_empty;
  logic [31:0]             off;
  rsp_t                    fifo_wdata, fifo_rdata;
  logic                    unused_off_lsb;

  // Request side: credits bound the number of fetches the FIFO may have to hold.
  assign ireqready_o = clk_en_i & ~reset_i & (outstanding_q < CREDITS);
  assign accept      = ireqvalid_i & ireqready_o;

  assign off            = ireqaddr_i - C_BASE_ADDR;
  assign in_range       = ((off[31:2] >> C_MEM_DEPTH_X) == '0);
  assign err            = ~in_range | ~HPL_OK[ireqhpl_i];
  assign mem_en_o       = accept & ~err;
  assign mem_addr_o     = off[C_MEM_DEPTH_X+1:2];
  assign unused_off_lsb = ^off[1:0];

  // Response side: head of the FIFO, zeroed when nothing is presented.
  assign rsp_show    = ~fifo_empty & ~reset_i;
  assign irspvalid_o = clk_en_i & rsp_show;
  assign irsprerr_o  = rsp_show & fifo_rdata.err;
  assign irspdata_o  = rsp_show ? fifo_rdata.data : '0;
  assign pop         = irspvalid_o & irspready_i;

  assign fifo_wdata.err  = pipe_err_q[C_RD_LATENCY-1];
  assign fifo_wdata.data = pipe_err_q[C_RD_LATENCY-1] ? '0 : mem_rdata_i;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    // Stage 0 tracks the SRAM cycle just launched; the last stage meets its data.
    pipe_vld_d    = pipe_vld_q << 1;
    pipe_err_d    = pipe_err_q << 1;
    pipe_vld_d[0] = accept;
    pipe_err_d[0] = accept & err;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding_q <= '0;
      pipe_vld_q    <= '0;
      pipe_err_q    <= '0;
    end else if (clk_en_i) begin
      outstanding_q <= outstanding_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_err_q    <= pipe_err_d;
    end
  end

  merlin_fifo #(
    .C_FIFO_WIDTH  (RSP_W),
    .C_FIFO_DEPTH_X(C_RSP_FIFO_DEPTH_X)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clk_en_i(clk_en_i),
    .flush_i (reset_i),
    .wr_i    (pipe_vld_q[C_RD_LATENCY-1]),
    .wdata_i (fifo_wdata),
    .rd_i    (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty)
  );

endmodule
